// File: rtl/b11_feeder.sv
// -----------------------------------------------------------------------------
// b11_feeder
//   Upstream stage for the b11 modulo-arithmetic datapath. Words arrive on a
//   valid/ready interface and are buffered in a small FIFO. Each word is
//   launched into b11 by presenting it on x_in together with a one-cycle low
//   pulse on stbi. b11 has no back-pressure, so after every launch the feeder
//   waits GAP stbi-high cycles. This keeps b11 from receiving a strobe while it
//   is still busy. After reset, the feeder waits STARTUP cycles before the first
//   launch.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   din         in   [5:0] input word
//   din_valid   in   din is valid this cycle
//   din_ready   out  FIFO can accept a word (!full && !reset), combinational
//   x_in        out  [5:0] word presented to b11, registered
//   stbi        out  launch strobe, idles high, low one cycle per launch
//   busy        out  FSM not in IDLE, or FIFO not empty
//   fifo_level  out  [log2(DEPTH):0] current FIFO occupancy
//   issued_cnt  out  [7:0] number of launched words, wraps 255->0
// -----------------------------------------------------------------------------
module b11_feeder #(
   parameter int DEPTH   = 4,   // FIFO entries, power of 2 in 2..16
   parameter int GAP     = 32,  // idle cycles after each strobe, >= 28
   parameter int STARTUP = 4    // idle cycles after reset before first launch
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [5:0]               din,
   input  logic                     din_valid,
   output logic                     din_ready,
   output logic [5:0]               x_in,
   output logic                     stbi,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [7:0]               issued_cnt
);

   localparam int AW      = $clog2(DEPTH);
   localparam int LW      = AW + 1;
   localparam int CNT_MAX = ((GAP > STARTUP) ? GAP : STARTUP) - 1;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

   localparam logic [CW-1:0] START_LAST = CW'(STARTUP - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
   localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);

   typedef enum logic [1:0] {
      S_WAIT_START = 2'd0,
      S_IDLE       = 2'd1,
      S_STROBE     = 2'd2,
      S_GAP        = 2'd3
   } state_t;

   state_t          state_q,  state_d;
   logic [CW-1:0]   cnt_q,    cnt_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q,  level_d;
   logic [5:0]      x_in_q,   x_in_d;
   logic            stbi_q,   stbi_d;
   logic [7:0]      issued_q, issued_d;
   logic [5:0]      mem_q [DEPTH];

   logic            push;
   logic            pop;

   // When the FIFO is full, a word offered in the same cycle as a pop is refused.
   // It is accepted one cycle later, so the FIFO never overwrites an entry.
   assign din_ready = (level_q != LVL_FULL) && !reset;
   assign push      = din_valid && din_ready;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      x_in_d   = x_in_q;
      stbi_d   = 1'b1;
      issued_d = issued_q;
      pop      = 1'b0;

      case (state_q)
         S_WAIT_START: begin
            if (cnt_q == START_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            // The check uses the registered level. A word pushed into an empty
            // FIFO therefore launches one cycle after the push.
            if (level_q != '0) begin
               x_in_d  = mem_q[rd_ptr_q];
               stbi_d  = 1'b0;
               pop     = 1'b1;
               state_d = S_STROBE;
            end
         end
         S_STROBE: begin
            issued_d = issued_q + 1'b1;
            cnt_d    = '0;
            state_d  = S_GAP;
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_WAIT_START;
            cnt_d   = '0;
         end
      endcase

      // The pointers wrap naturally because DEPTH is a power of two.
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments, so every flop
      // samples the pre-edge value of every other flop.
      if (reset) begin
         state_q  <= S_WAIT_START;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         x_in_q   <= '0;
         stbi_q   <= 1'b1;
         issued_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         x_in_q   <= x_in_d;
         stbi_q   <= stbi_d;
         issued_q <= issued_d;
      end
   end

   // NOTE: the storage array has no reset. Clearing the level and the pointers
   // already discards its contents, and no entry is read until it has been written.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign x_in       = x_in_q;
   assign stbi       = stbi_q;
   assign busy       = (state_q != S_IDLE) || (level_q != '0);
   assign fifo_level = level_q;
   assign issued_cnt = issued_q;

endmodule

// File: tb/tb_b11_feeder.sv
// -----------------------------------------------------------------------------
// tb_b11_feeder
//   Self-checking bench for b11_feeder. Every accepted word is pushed to a
//   scoreboard queue. A negedge monitor pops the queue on every stbi-low cycle
//   and checks launch order, strobe spacing and x_in stability. Scenario tasks
//   check cycle-exact timing, FIFO levels and counters.
//   STARTUP is set to 8. With this value, six back-to-back offers right after
//   reset all land inside WAIT_START.
// -----------------------------------------------------------------------------
module tb_b11_feeder;

   localparam int DEPTH   = 4;
   localparam int GAP     = 32;
   localparam int STARTUP = 8;
   localparam int LW      = $clog2(DEPTH) + 1;
   localparam int DRAIN   = DEPTH * (GAP + 2) + 50;

   logic          clock;
   logic          reset;
   logic [5:0]    din;
   logic          din_valid;
   logic          din_ready;
   logic [5:0]    x_in;
   logic          stbi;
   logic          busy;
   logic [LW-1:0] fifo_level;
   logic [7:0]    issued_cnt;

   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   int            last_strobe = -1;
   int            strobe_cycles[$];
   logic [5:0]    sb_q[$];
   logic [5:0]    prev_x;
   logic [5:0]    exp_w;

   b11_feeder #(.DEPTH(DEPTH), .GAP(GAP), .STARTUP(STARTUP)) dut (
      .clock      (clock),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .x_in       (x_in),
      .stbi       (stbi),
      .busy       (busy),
      .fifo_level (fifo_level),
      .issued_cnt (issued_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change only at negedge+1. At each negedge, reset therefore still
   // shows the value that the preceding posedge sampled.
   always @(negedge clock) begin
      cyc++;
      if (reset === 1'b1) begin
         last_strobe = -1;
      end else begin
         checks++;
         if (x_in !== prev_x && stbi !== 1'b0) begin
            failures++;
            $display("FAIL x_in_stable: x_in=%0h without strobe, required %0h", x_in, prev_x);
         end
         if (stbi === 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL launch_order: strobe with x_in=%0h, required no strobe", x_in);
            end else begin
               exp_w = sb_q.pop_front();
               if (x_in !== exp_w) begin
                  failures++;
                  $display("FAIL launch_order: x_in=%0h required %0h", x_in, exp_w);
               end
            end
            if (last_strobe >= 0) begin
               checks++;
               if (cyc - last_strobe < GAP + 2) begin
                  failures++;
                  $display("FAIL strobe_spacing: %0d cycles, required >= %0d", cyc - last_strobe, GAP + 2);
               end
            end
            last_strobe = cyc;
            strobe_cycles.push_back(cyc);
         end
      end
      prev_x = x_in;
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic offer(input logic [5:0] w, output logic acc);
      din       = w;
      din_valid = 1'b1;
      #1;
      acc = din_ready;
      if (acc) sb_q.push_back(w);
   endtask

   task automatic do_reset();
      din_valid = 1'b0;
      reset     = 1'b1;
      step();
      step();
      reset = 1'b0;
      sb_q.delete();
      strobe_cycles.delete();
   endtask

   task automatic wait_strobe(input int limit, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         step();
         if (stbi === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic drain(input string name);
      logic ok;
      ok = 1'b0;
      din_valid = 1'b0;
      for (int i = 0; i < DRAIN; i++) begin
         step();
         if (busy === 1'b0 && sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_drain: busy=%0b pending=%0d, required idle and empty", name, busy, sb_q.size());
      end
   endtask

   task automatic test_reset();
      din       = 6'h3f;
      din_valid = 1'b1;
      reset     = 1'b1;
      step();
      step();
      checks++;
      if ({stbi, x_in, fifo_level, issued_cnt, busy, din_ready} !== {1'b1, 6'h00, LW'(0), 8'h00, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset_state: stbi=%0b x_in=%0h lvl=%0d iss=%0d busy=%0b rdy=%0b, required 1 0 0 0 1 0",
                  stbi, x_in, fifo_level, issued_cnt, busy, din_ready);
      end
      din_valid = 1'b0;
      reset     = 1'b0;
      sb_q.delete();
      repeat (STARTUP - 1) step();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL startup_busy: busy=%0b required 1", busy);
      end
      step();
      checks++;
      if (busy !== 1'b0 || stbi !== 1'b1) begin
         failures++;
         $display("FAIL startup_idle: busy=%0b stbi=%0b, required 0 1", busy, stbi);
      end
   endtask

   task automatic test_single_word();
      logic acc;
      do_reset();
      repeat (9) step();
      offer(6'h05, acc);
      checks++;
      if (acc !== 1'b1) begin
         failures++;
         $display("FAIL single_accept: din_ready=%0b required 1", acc);
      end
      step();
      din_valid = 1'b0;
      checks++;
      if (stbi !== 1'b1 || fifo_level !== LW'(1)) begin
         failures++;
         $display("FAIL single_queued: stbi=%0b lvl=%0d, required 1 1", stbi, fifo_level);
      end
      step();
      checks++;
      if (stbi !== 1'b0 || x_in !== 6'h05 || fifo_level !== LW'(0)) begin
         failures++;
         $display("FAIL single_latency: stbi=%0b x_in=%0h lvl=%0d, required 0 05 0", stbi, x_in, fifo_level);
      end
      step();
      checks++;
      if (stbi !== 1'b1 || issued_cnt !== 8'd1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_issued: stbi=%0b iss=%0d busy=%0b, required 1 1 1", stbi, issued_cnt, busy);
      end
      repeat (GAP - 1) step();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL single_gap_busy: busy=%0b required 1", busy);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL single_gap_end: busy=%0b required 0", busy);
      end
      drain("single");
   endtask

   task automatic test_back_to_back();
      logic [5:0] words [4];
      int         lvl_exp [4];
      int         drops;
      logic       acc;
      words   = '{6'h00, 6'h3f, 6'h1a, 6'h1b};
      lvl_exp = '{1, 1, 2, 3};
      drops   = 0;
      do_reset();
      repeat (9) step();
      for (int i = 0; i < 4; i++) begin
         offer(words[i], acc);
         if (!acc) drops++;
         step();
         checks++;
         if (fifo_level !== LW'(lvl_exp[i])) begin
            failures++;
            $display("FAIL b2b_level_%0d: lvl=%0d required %0d", i, fifo_level, lvl_exp[i]);
         end
      end
      din_valid = 1'b0;
      for (int i = 0; i < 4 * (GAP + 2) + 20 && strobe_cycles.size() < 4; i++) begin
         step();
         if (din_ready !== 1'b1) drops++;
      end
      checks++;
      if (drops != 0) begin
         failures++;
         $display("FAIL b2b_ready: din_ready low %0d times, required 0", drops);
      end
      checks++;
      if (strobe_cycles.size() != 4) begin
         failures++;
         $display("FAIL b2b_count: %0d strobes, required 4", strobe_cycles.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (strobe_cycles[i] - strobe_cycles[i-1] != GAP + 2) begin
               failures++;
               $display("FAIL b2b_spacing_%0d: %0d cycles, required %0d", i,
                        strobe_cycles[i] - strobe_cycles[i-1], GAP + 2);
            end
         end
      end
      drain("b2b");
   endtask

   task automatic test_fill_startup();
      logic acc;
      logic ok;
      logic exp_acc [6];
      exp_acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         offer(6'h20 + 6'(i), acc);
         checks++;
         if (acc !== exp_acc[i]) begin
            failures++;
            $display("FAIL fill_ready_%0d: din_ready=%0b required %0b", i, acc, exp_acc[i]);
         end
         step();
      end
      din_valid = 1'b0;
      checks++;
      if (fifo_level !== LW'(4)) begin
         failures++;
         $display("FAIL fill_full: lvl=%0d required 4", fifo_level);
      end
      for (int k = 0; k < 4; k++) begin
         wait_strobe(2 * (GAP + 2), ok);
         checks++;
         if (!ok || fifo_level !== LW'(3 - k)) begin
            failures++;
            $display("FAIL fill_launch_%0d: seen=%0b lvl=%0d, required 1 %0d", k, ok, fifo_level, 3 - k);
         end
      end
      drain("fill");
      checks++;
      if (strobe_cycles.size() != 4) begin
         failures++;
         $display("FAIL fill_count: %0d launches, required 4", strobe_cycles.size());
      end
   endtask

   task automatic test_full_stream();
      logic [5:0] word;
      logic       acc;
      logic       after;
      int         bad;
      word  = 6'h10;
      after = 1'b0;
      bad   = 0;
      do_reset();
      for (int i = 0; i < 400 && strobe_cycles.size() < 5; i++) begin
         offer(word, acc);
         if (acc) word = word + 6'd1;
         step();
         if (stbi === 1'b0) begin
            if (fifo_level !== LW'(3)) bad++;
            after = 1'b1;
         end else if (after) begin
            if (fifo_level !== LW'(4)) bad++;
            after = 1'b0;
         end
      end
      din_valid = 1'b0;
      checks++;
      if (bad != 0 || strobe_cycles.size() != 5) begin
         failures++;
         $display("FAIL stream_level: %0d level errors over %0d launches, required 0 over 5", bad, strobe_cycles.size());
      end
      drain("stream");
      checks++;
      if (issued_cnt !== 8'(strobe_cycles.size())) begin
         failures++;
         $display("FAIL stream_issued: iss=%0d required %0d", issued_cnt, strobe_cycles.size());
      end
   endtask

   task automatic test_reset_in_strobe();
      logic acc;
      logic ok;
      int   early;
      early = 0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         offer(6'h28 + 6'(i), acc);
         step();
      end
      din_valid = 1'b0;
      wait_strobe(2 * (GAP + 2), ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL rst_strobe_seen: no strobe, required one");
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      sb_q.delete();
      strobe_cycles.delete();
      checks++;
      if ({stbi, x_in, fifo_level, issued_cnt, busy} !== {1'b1, 6'h00, LW'(0), 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL rst_strobe_state: stbi=%0b x_in=%0h lvl=%0d iss=%0d busy=%0b, required 1 0 0 0 1",
                  stbi, x_in, fifo_level, issued_cnt, busy);
      end
      for (int i = 0; i < STARTUP; i++) begin
         offer(6'h30 + 6'(i), acc);
         step();
         if (stbi !== 1'b1) early++;
      end
      din_valid = 1'b0;
      checks++;
      if (early != 0) begin
         failures++;
         $display("FAIL rst_strobe_quiet: %0d early strobes, required 0", early);
      end
      step();
      checks++;
      if (stbi !== 1'b0 || x_in !== 6'h30) begin
         failures++;
         $display("FAIL rst_strobe_first: stbi=%0b x_in=%0h, required 0 30", stbi, x_in);
      end
      drain("rst_strobe");
   endtask

   task automatic test_wrap();
      logic [5:0] word;
      logic       acc;
      word = 6'h01;
      do_reset();
      for (int i = 0; i < 256 * (GAP + 2) + 100 && strobe_cycles.size() < 256; i++) begin
         offer(word, acc);
         if (acc) word = word + 6'd3;
         step();
      end
      din_valid = 1'b0;
      checks++;
      if (strobe_cycles.size() != 256 || issued_cnt !== 8'd255) begin
         failures++;
         $display("FAIL wrap_before: %0d launches iss=%0d, required 256 255", strobe_cycles.size(), issued_cnt);
      end
      step();
      checks++;
      if (issued_cnt !== 8'd0) begin
         failures++;
         $display("FAIL wrap_after: iss=%0d required 0", issued_cnt);
      end
      drain("wrap");
   endtask

   initial begin
      reset     = 1'b1;
      din       = '0;
      din_valid = 1'b0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_fill_startup();
      test_full_stream();
      test_reset_in_strobe();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
